// File: rtl/serial_frame_tx_if.sv
// Load handshake between a word producer and serial_frame_tx.
// The producer drives data_in/load_valid; the transmitter answers with load_ready.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Each bit is held CLKS_PER_BIT cycles; tx_out comes straight from a flop so the line is glitch-free.
module serial_frame_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  serial_frame_tx_if.slave ld,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic             tx_nxt;
  logic             done_nxt;
  logic             bit_end;

  assign bit_end       = (cyc_cnt == CYC_LAST);
  assign ld.load_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      tx_out  <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_nxt;
      cyc_cnt <= cyc_nxt;
      tx_out  <= tx_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    cyc_nxt   = cyc_cnt;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;

    unique case (state)
      IDLE: begin
        if (ld.load_valid) begin
          state_nxt = START;
          shreg_nxt = ld.data_in;
          bit_nxt   = '0;
          cyc_nxt   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is derived from the next state so tx_out changes on the same edge as the state.
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: (8,4) and (4,1) instances, expected line levels queued per cycle.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic e;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  serial_frame_tx_if #(.WIDTH(8)) ifa ();
  serial_frame_tx_if #(.WIDTH(4)) ifb ();

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(rst_n), .ld(ifa), .tx_out(tx_a), .busy(busy_a), .done(done_a)
  );

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(rst_n), .ld(ifb), .tx_out(tx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_frame(input logic [31:0] d, input int w, input int cpb);
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
    for (int j = 0; j < w; j++)
      for (int c = 0; c < cpb; c++) exp_q.push_back(d[j]);
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifa.load_valid = 1'b1; ifa.data_in = 8'hAA;
    ifb.load_valid = 1'b1; ifb.data_in = 4'hA;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
      total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_a); end
      total++; if (ifa.load_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ifa.load_ready); end
      total++; if (tx_b !== 1'b1) begin bad++; $display("FAIL rst_tx_b got=%b exp=1", tx_b); end
    end
    ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", tx_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_a); end
      total++; if (done_a !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", done_a); end
      total++; if (tx_b !== 1'b1 || busy_b !== 1'b0) begin bad++; $display("FAIL idle_b got=%b%b exp=10", tx_b, busy_b); end
    end
  endtask

  task automatic test_single();
    exp_q.delete();
    push_frame(32'hA5, 8, 4);
    @(negedge clk); ifa.data_in = 8'hA5; ifa.load_valid = 1'b1;
    @(posedge clk); #1 ifa.load_valid = 1'b0; ifa.data_in = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_a !== e) begin bad++; $display("FAIL a5_tx[%0d] got=%b exp=%b", i, tx_a, e); end
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL a5_busy[%0d] got=%b exp=1", i, busy_a); end
      total++; if (done_a !== 1'b0) begin bad++; $display("FAIL a5_early_done[%0d] got=%b exp=0", i, done_a); end
    end
    @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL a5_done got=%b exp=1", done_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL a5_busy_end got=%b exp=0", busy_a); end
    total++; if (ifa.load_ready !== 1'b1) begin bad++; $display("FAIL a5_ready got=%b exp=1", ifa.load_ready); end
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL a5_tx_idle got=%b exp=1", tx_a); end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL a5_done_pulse got=%b exp=0", done_a); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL a5_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_data_hold();
    exp_q.delete();
    push_frame(32'h3C, 8, 4);
    @(negedge clk); ifa.data_in = 8'h3C; ifa.load_valid = 1'b1;
    @(posedge clk); #1 ifa.load_valid = 1'b0; ifa.data_in = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_a !== e) begin bad++; $display("FAIL hold_tx[%0d] got=%b exp=%b", i, tx_a, e); end
      total++; if (ifa.load_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, ifa.load_ready); end
      ifa.load_valid = (i % 7 == 3);
      ifa.data_in    = 8'($urandom);
    end
    ifa.load_valid = 1'b0;
    @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL hold_done got=%b exp=1", done_a); end
    repeat (3) begin
      @(negedge clk);
      total++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin bad++; $display("FAIL hold_idle got=%b%b exp=01", busy_a, tx_a); end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    push_frame(32'h01, 8, 4);
    exp_q.push_back(1'b1);
    push_frame(32'h80, 8, 4);
    @(negedge clk); ifa.data_in = 8'h01; ifa.load_valid = 1'b1;
    @(posedge clk); #1 ifa.data_in = 8'h80;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_a !== e) begin bad++; $display("FAIL b2b_tx[%0d] got=%b exp=%b", i, tx_a, e); end
      total++; if (busy_a !== (i != 40)) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy_a, (i != 40)); end
      total++; if (done_a !== (i == 40)) begin bad++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done_a, (i == 40)); end
      if (i == 40) begin
        total++; if (ifa.load_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", ifa.load_ready); end
      end
      if (i == 41) ifa.load_valid = 1'b0;
    end
    @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done_a); end
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b exp=0", busy_a); end
  endtask

  task automatic test_mid_reset();
    exp_q.delete();
    push_frame(32'h55, 8, 4);
    @(negedge clk); ifa.data_in = 8'h55; ifa.load_valid = 1'b1;
    @(posedge clk); #1 ifa.load_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_a !== e) begin bad++; $display("FAIL mid_tx[%0d] got=%b exp=%b", i, tx_a, e); end
    end
    // Reset lands between clock edges; the line must rise before the next edge.
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL mid_async_tx got=%b exp=1", tx_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_async_busy got=%b exp=0", busy_a); end
    total++; if (ifa.load_ready !== 1'b1) begin bad++; $display("FAIL mid_async_ready got=%b exp=1", ifa.load_ready); end
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      total++; if (done_a !== 1'b0 || tx_a !== 1'b1) begin bad++; $display("FAIL mid_hold got=%b%b exp=01", done_a, tx_a); end
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if (done_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin bad++; $display("FAIL mid_after got=%b%b%b exp=001", done_a, busy_a, tx_a); end
    end
    push_frame(32'h0F, 8, 4);
    ifa.data_in = 8'h0F; ifa.load_valid = 1'b1;
    @(posedge clk); #1 ifa.load_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_a !== e) begin bad++; $display("FAIL f0_tx[%0d] got=%b exp=%b", i, tx_a, e); end
    end
    @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL f0_done got=%b exp=1", done_a); end
  endtask

  task automatic test_cpb1();
    exp_q.delete();
    push_frame(32'h9, 4, 1);
    @(negedge clk); ifb.data_in = 4'b1001; ifb.load_valid = 1'b1;
    @(posedge clk); #1 ifb.load_valid = 1'b0; ifb.data_in = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (tx_b !== e) begin bad++; $display("FAIL c1_tx[%0d] got=%b exp=%b", i, tx_b, e); end
      total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL c1_busy[%0d] got=%b exp=1", i, busy_b); end
    end
    @(negedge clk);
    total++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin bad++; $display("FAIL c1_done got=%b%b exp=10", done_b, busy_b); end
    @(negedge clk);
    total++; if (done_b !== 1'b0 || tx_b !== 1'b1) begin bad++; $display("FAIL c1_after got=%b%b exp=01", done_b, tx_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_data_hold();
    test_back_to_back();
    test_mid_reset();
    test_cpb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
